// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Optional feature macro: IMEM_PARITY_EN (per-word even parity).
package imem_responder_pkg;

    localparam int unsigned WORD_W = 12;
    localparam int unsigned ADDR_W = 12;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Instruction returned for out-of-range fetches
    localparam word_t NOP_WORD = 12'h000;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Even-parity bit: makes the XOR over {parity, word} zero
    function automatic logic even_parity(input word_t w);
        return ^w;
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch, response and boot-load signals between fetch stage and responder.
interface imem_responder_if;
    import imem_responder_pkg::*;

    logic  req_valid;
    addr_t req_addr;
    logic  req_ready;
    logic  rsp_valid;
    word_t rsp_data;
    addr_t rsp_addr;
    logic  rsp_err;
    logic  ld_start;
    logic  ld_valid;
    word_t ld_data;
    logic  ld_ready;
    logic  ld_done;

    modport master (
        output req_valid, req_addr, ld_start, ld_valid, ld_data,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, ld_ready, ld_done
    );

    modport slave (
        input  req_valid, req_addr, ld_start, ld_valid, ld_data,
        output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, ld_ready, ld_done
    );

endinterface

// File: rtl/imem_array.sv
// Instruction storage: one write port, one registered read port.
// With IMEM_PARITY_EN each word is widened by an even-parity bit and the
// read port flags a parity mismatch on rd_fault_o.
module imem_array
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 4096
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  we_i,
    input  addr_t wr_addr_i,
    input  word_t wr_data_i,
    input  logic  rd_en_i,
    input  logic  rd_clr_i,
    input  addr_t rd_addr_i,
    output word_t rd_data_o,
    output logic  rd_fault_o
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
    localparam int unsigned STORE_W = WORD_W + 1;
`else
    localparam int unsigned STORE_W = WORD_W;
`endif

    logic [STORE_W-1:0] mem_q [DEPTH];
    logic [STORE_W-1:0] wr_word;
    logic [STORE_W-1:0] rd_word;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic               rd_fault;
    word_t              rd_data_q;
    logic               rd_fault_q;
    logic               unused_addr_bits;

    // Caller guarantees addresses are below DEPTH; upper bits are don't-care
    assign wr_idx           = wr_addr_i[IDX_W-1:0];
    assign rd_idx           = rd_addr_i[IDX_W-1:0];
    assign unused_addr_bits = ^{wr_addr_i, rd_addr_i};
    assign rd_word          = mem_q[rd_idx];

`ifdef IMEM_PARITY_EN
    assign wr_word  = {even_parity(wr_data_i), wr_data_i};
    assign rd_fault = ^rd_word;
`else
    assign wr_word  = wr_data_i;
    assign rd_fault = 1'b0;
`endif

    // Storage write; contents deliberately have no reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_idx] <= wr_word;
        end
    end

    // Read register: loads a word, or NOP-with-fault when cleared, else holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= NOP_WORD;
            rd_fault_q <= 1'b0;
        end else if (rd_clr_i) begin
            rd_data_q  <= NOP_WORD;
            rd_fault_q <= 1'b1;
        end else if (rd_en_i) begin
            rd_data_q  <= rd_word[WORD_W-1:0];
            rd_fault_q <= rd_fault;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_fault_o = rd_fault_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: boot-loads LOAD_WORDS words, then serves
// pipelined single-cycle-latency fetches. Optional macro IMEM_PARITY_EN
// (handled inside imem_array) reports parity errors on rsp_err.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned LOAD_WORDS = 256
) (
    input logic               clk,
    input logic               rst,
    imem_responder_if.slave   bus
);

    localparam addr_t LAST_WORD = ADDR_W'(LOAD_WORDS - 1);

    state_e state_q, state_d;
    addr_t  ld_cnt_q, ld_cnt_d;
    logic   ld_done_q, ld_done_d;
    logic   req_ready_q;
    logic   ld_ready_q;
    logic   rsp_valid_q;
    addr_t  rsp_addr_q;
    logic   ld_fire;
    logic   accept;
    logic   in_range;
    word_t  rd_data;
    logic   rd_fault;

    assign accept   = bus.req_valid && req_ready_q;
    assign in_range = 32'(bus.req_addr) < DEPTH;

    // Next-state: load counter sequencing and LOAD/RUN transitions
    always_comb begin
        state_d   = state_q;
        ld_cnt_d  = ld_cnt_q;
        ld_done_d = 1'b0;
        ld_fire   = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (bus.ld_start) begin
                    ld_cnt_d = '0;
                end else if (bus.ld_valid) begin
                    ld_fire = 1'b1;
                    if (ld_cnt_q == LAST_WORD) begin
                        ld_cnt_d  = '0;
                        ld_done_d = 1'b1;
                        state_d   = ST_RUN;
                    end else begin
                        ld_cnt_d = ld_cnt_q + ADDR_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (bus.ld_start) begin
                    state_d  = ST_LOAD;
                    ld_cnt_d = '0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // State register; ready flags registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            ld_cnt_q    <= '0;
            ld_done_q   <= 1'b0;
            req_ready_q <= 1'b0;
            ld_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            ld_done_q   <= ld_done_d;
            req_ready_q <= (state_d == ST_RUN);
            ld_ready_q  <= (state_d == ST_LOAD);
        end
    end

    // Response valid/address tracking; address holds when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_addr_q <= bus.req_addr;
            end
        end
    end

    imem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .we_i       (ld_fire),
        .wr_addr_i  (ld_cnt_q),
        .wr_data_i  (bus.ld_data),
        .rd_en_i    (accept && in_range),
        .rd_clr_i   (accept && !in_range),
        .rd_addr_i  (bus.req_addr),
        .rd_data_o  (rd_data),
        .rd_fault_o (rd_fault)
    );

    assign bus.req_ready = req_ready_q;
    assign bus.ld_ready  = ld_ready_q;
    assign bus.ld_done   = ld_done_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_data  = rd_data;
    assign bus.rsp_err   = rd_fault;

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DEPTH, default 4096: number of 12-bit instruction words stored; legal range 2..4096.
REQ-002 Parameter LOAD_WORDS, default 256: number of words written by the boot-load sequence; legal range 1..DEPTH.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  fetch request from the fetch stage.
REQ-006 req_addr  input  12  fetch word address (PC).
REQ-007 req_ready  output  1  responder accepts a fetch this cycle.
REQ-008 rsp_valid  output  1  rsp_data/rsp_addr are valid.
REQ-009 rsp_data  output  12  fetched instruction word.
REQ-010 rsp_addr  output  12  address the rsp_data belongs to.
REQ-011 rsp_err  output  1  the current response is an error response.
REQ-012 ld_start  input  1  single-cycle pulse that restarts the boot-load sequence.
REQ-013 ld_valid  input  1  load word present.
REQ-014 ld_data  input  12  load word.
REQ-015 ld_ready  output  1  responder accepts a load word this cycle.
REQ-016 ld_done  output  1  one-cycle pulse when the last load word is written.

Function
REQ-017 FSM states: LOAD and RUN only.
REQ-018 In LOAD: ld_ready=1 and req_ready=0; each ld_valid&&ld_ready cycle writes ld_data at load counter ld_cnt, then increments ld_cnt.
REQ-019 A write with ld_cnt==LOAD_WORDS-1 pulses ld_done on the next cycle, clears ld_cnt to 0, and moves the FSM to RUN.
REQ-020 In RUN: req_ready=1 and ld_ready=0; ld_valid is ignored.
REQ-021 A fetch is accepted on req_valid&&req_ready; one cycle later rsp_valid=1, rsp_addr=req_addr, rsp_data=mem[req_addr].
REQ-022 Fetches are fully pipelined: one accept per cycle, fixed 1-cycle latency, no response backpressure.
REQ-023 req_addr>=DEPTH: response is rsp_data=12'h000 (NOP) with rsp_err=1 and rsp_valid=1; memory is not accessed.
REQ-024 rsp_valid=0 in any cycle following a cycle with no accepted fetch; rsp_data/rsp_addr then hold their last values.
REQ-025 ld_start in RUN: next cycle FSM=LOAD and ld_cnt=0; a fetch accepted in the ld_start cycle still produces its response.
REQ-026 ld_start in LOAD: ld_cnt restarts at 0; a coincident ld_valid word is discarded.
REQ-027 Memory contents are not reset; reads of unloaded words return undefined data without error.

Reset
REQ-028 On rst: FSM=LOAD, ld_cnt=0, req_ready=0, ld_ready=1, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_err=0, ld_done=0.
REQ-029 rst asserted mid-load or mid-fetch discards all in-flight work; the load sequence restarts at word 0 after release.

Configuration
REQ-030 Macro IMEM_PARITY_EN defined: each stored word carries an even-parity bit computed on write; a fetch whose parity mismatches returns the stored data with rsp_err=1.
REQ-031 Macro IMEM_PARITY_EN undefined: no parity storage; rsp_err asserts only for out-of-range addresses.

Structure
REQ-032 Shared package holds the 12-bit word and address widths, the NOP encoding 12'h000, and the LOAD/RUN state encoding.
REQ-033 Storage is a single sub-module imem_array (1 write port, 1 synchronous read port), optionally widened by one parity bit.

Verification
REQ-034 Reset, then load words 0..255 with ld_data=addr^12'hA5A -> ld_done pulses once after word 255, req_ready=1 on the following cycle.
REQ-035 Back-to-back fetches of 0x000, 0x001, 0x0FF -> three consecutive rsp_valid cycles, rsp_data=0xA5A, 0xA5B, 0xAA5, each one cycle after its accept.
REQ-036 DEPTH=2048, fetch 0x800 -> rsp_valid=1, rsp_data=0x000, rsp_err=1; the following fetch of 0x010 returns rsp_err=0.
REQ-037 ld_start coincident with an accepted fetch of 0x005 -> response 0xA5F delivered next cycle, req_ready=0 from that cycle, load restarts at word 0.
REQ-038 Assert rst after 100 load words -> all outputs at reset values; a fresh load of 256 words completes with a single ld_done.
REQ-039 With IMEM_PARITY_EN defined, force a parity flip at address 0x010 -> fetch returns rsp_err=1; without the macro the same fetch returns rsp_err=0.
